// File: rtl/agnus_audio_dma.sv
// Agnus audio DMA engine: latches Paula's per-channel requests at the line
// strobe and fetches one word per channel in its fixed colour-clock slot.
// Ports:
//   clk, reset_n, clk7_en    - clock, async active-low reset, state enable
//   cck, hpos, strhor        - beam timing: colour clock, position, line strobe
//   audio_dmal/dmas, aud_en  - Paula request/restart flags, channel enables
//   reg_address_in, data_in  - register write bus (AUDxLCH/AUDxLCL decode)
//   dma, address_out         - bus ownership and chip word address
//   reg_address_out          - AUDxDAT target for the fetched word, 0xFF idle

module agnus_audio_dma (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic        cck,
    input  logic [7:0]  hpos,
    input  logic        strhor,
    input  logic [3:0]  audio_dmal,
    input  logic [3:0]  audio_dmas,
    input  logic [3:0]  aud_en,
    input  logic [7:0]  reg_address_in,
    input  logic [15:0] data_in,
    output logic        dma,
    output logic [19:0] address_out,
    output logic [7:0]  reg_address_out
);

    localparam logic [7:0] SLOT_POS [4] = '{8'h0D, 8'h0F, 8'h11, 8'h13};
    localparam logic [7:0] LCH_REG  [4] = '{8'h50, 8'h58, 8'h60, 8'h68};
    localparam logic [7:0] LCL_REG  [4] = '{8'h51, 8'h59, 8'h61, 8'h69};
    localparam logic [7:0] DAT_REG  [4] = '{8'h55, 8'h5D, 8'h65, 8'h6D};
    localparam logic [7:0] IDLE_REG = 8'hFF;

    logic [19:0] lc_q [4];
    logic [19:0] lc_d [4];
    logic [19:0] pt_q [4];
    logic [19:0] pt_d [4];
    logic [3:0]  req_q, req_d;
    logic [3:0]  spec_q, spec_d;

    logic [3:0]  slot_hit;
    logic [19:0] fetch_addr [4];

    // Bit 0 of the LCL write is the byte lane, not part of the word address.
    logic unused_lsb;
    assign unused_lsb = data_in[0];

    // Slot decode and the address each channel would fetch from.
    always_comb begin
        for (int x = 0; x < 4; x++) begin
            slot_hit[x] = cck && (hpos == SLOT_POS[x])
                          && req_q[x] && aud_en[x];
            fetch_addr[x] = spec_q[x] ? lc_q[x] : pt_q[x];
        end
    end

    // Slots are distinct, so at most one channel drives the outputs.
    always_comb begin
        dma             = 1'b0;
        address_out     = 20'h00000;
        reg_address_out = IDLE_REG;
        for (int x = 0; x < 4; x++) begin
            if (slot_hit[x]) begin
                dma             = 1'b1;
                address_out     = fetch_addr[x];
                reg_address_out = DAT_REG[x];
            end
        end
    end

    // Next state. The fetch uses lc_q, so a same-cycle LC write only
    // affects later restarts. A strobe load overrides a slot's clear.
    always_comb begin
        req_d  = req_q;
        spec_d = spec_q;
        for (int x = 0; x < 4; x++) begin
            lc_d[x] = lc_q[x];
            pt_d[x] = pt_q[x];
            if (reg_address_in == LCH_REG[x])
                lc_d[x][19:15] = data_in[4:0];
            if (reg_address_in == LCL_REG[x])
                lc_d[x][14:0] = data_in[15:1];
            if (slot_hit[x]) begin
                pt_d[x]   = fetch_addr[x] + 20'd1;
                req_d[x]  = 1'b0;
                spec_d[x] = 1'b0;
            end
        end
        if (strhor) begin
            req_d  = audio_dmal;
            spec_d = audio_dmas;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int x = 0; x < 4; x++) begin
                lc_q[x] <= 20'h00000;
                pt_q[x] <= 20'h00000;
            end
            req_q  <= 4'h0;
            spec_q <= 4'h0;
        end else if (clk7_en) begin
            for (int x = 0; x < 4; x++) begin
                lc_q[x] <= lc_d[x];
                pt_q[x] <= pt_d[x];
            end
            req_q  <= req_d;
            spec_q <= spec_d;
        end
    end

endmodule

// File: doc/agnus_audio_dma.md
# agnus_audio_dma

Agnus-side audio DMA engine for the four Paula audio channels. Latches each channel's DMA request and restart flag at the horizontal strobe and services it in that channel's fixed audio slot: it drives the chip-RAM word address and presents the fetched word to Paula as a write to that channel's AUDxDAT register. It owns the AUDxLC location registers and the running AUDxPT pointers, and sits in the Agnus DMA slot multiplexer beside the bitplane, sprite and disk engines.

## Interface
- No parameters. Slot positions and register addresses are fixed constants.
- clk — in — 1 — bus clock.
- reset_n — in — 1 — asynchronous active-low reset.
- clk7_en — in — 1 — clock enable. All state updates occur only on clk edges with clk7_en=1.
- cck — in — 1 — colour clock enable qualifier for slot cycles.
- hpos — in — 8 — horizontal beam position in colour clocks.
- strhor — in — 1 — horizontal strobe, one clk7_en cycle at line start. Paula clears its requests on this same strobe.
- audio_dmal — in — 4 — per-channel DMA request from Paula (bit x = channel x).
- audio_dmas — in — 4 — per-channel restart request from Paula.
- aud_en — in — 4 — per-channel enable: DMAEN & AUDxEN.
- reg_address_in — in — 8 — register address [8:1] of the current CPU/copper write.
- data_in — in — 16 — register write data.
- dma — out — 1 — this block owns the chip bus in the current slot.
- address_out — out — 20 — chip word address [20:1]. Zero when dma=0.
- reg_address_out — out — 8 — register address [8:1] for the fetched word. AUDxDAT when dma=1, 0xFF (0x1FE, idle) otherwise.

## Operation
- Registers per channel x (0..3):
  - lc[x], 20 bits. AUDxLCH at 0x0A0+0x10·x writes lc[19:15] <= data_in[4:0]. AUDxLCL at 0x0A2+0x10·x writes lc[14:0] <= data_in[15:1].
  - pt[x], 20 bits.
  - req[x], spec[x] request latches.
- Reset (async, reset_n=0): lc, pt, req, spec all 0. Outputs dma=0, address_out=0, reg_address_out=0xFF.
- Strobe: on clk7_en && strhor, req <= audio_dmal and spec <= audio_dmas. Bits with audio_dmal=0 are cleared. Outside strhor, the latches change only when a slot is serviced.
- Slots: channel 0/1/2/3 at hpos 0x0D/0x0F/0x11/0x13, qualified by cck. A slot is active when cck && hpos==slot(x) && req[x] && aud_en[x].
- Active slot, combinational outputs:
  - dma=1.
  - reg_address_out = (0x0AA+0x10·x)>>1.
  - address_out = spec[x] ? lc[x] : pt[x].
- Active slot, updates at the clk7_en edge ending the slot:
  - pt[x] <= (spec[x] ? lc[x] : pt[x]) + 1, modulo 2^20 (0xFFFFF wraps to 0x00000).
  - req[x] <= 0, spec[x] <= 0.
- Inactive slot (req=0 or aud_en=0): no bus use, outputs idle, latches unchanged. A request not serviced is dropped at the next strhor unless Paula re-asserts it.
- At most one channel is active per cycle; slots are distinct.

## Timing
- Latency: request present at strhor → data delivered in the same line's slot. Total per channel is ≤1 word per line.
- Outputs are combinational from hpos/cck/state and valid only during the slot cycle. Pointer advance is visible from the next cycle.
- Simultaneous LC write and restart fetch on the same channel: the fetch and the pt reload use the old lc; the new lc applies afterwards.
- Simultaneous strhor and slot: the slot uses the pre-strobe latches, and the strobe's load overrides the slot's clear (load wins).
- Simultaneous aud_en fall and slot: no fetch; req is held until the next strhor.
- Writes to LCH and LCL are independent; no ordering is required.

## Test plan
- Reset: assert reset_n=0 mid-line with req set → dma=0, reg_address_out=0xFF, pt=lc=0 immediately, no slot fetch that line.
- Restart:
  - Stimulus: write AUD0LCH=0x0001, AUD0LCL=0x2340; dmal[0]=dmas[0]=1 at strhor.
  - Slot 0x0D: address_out=0x091A0, reg_address_out=0x55 (0x0AA), dma=1. Then pt[0]=0x091A1.
  - Next line with dmal=1, dmas=0 → address_out=0x091A1, then pt[0]=0x091A2.
- Wrap: ch3 with lc=0xFFFFF (LCH=0x001F, LCL=0xFFFE), restart → address_out=0xFFFFF, pt[3]=0x00000. Next fetch at 0x00000 at hpos 0x13, reg_address_out=0x6D (0x0DA).
- Gating: dmal[2]=1, aud_en[2]=0 → no dma at hpos 0x11. Then aud_en[2]=1 next line without re-request → no fetch (latch reloaded 0 at strhor).
- All four channels requested in one line → exactly four single-cycle dma pulses at 0x0D/0x0F/0x11/0x13 with the correct AUDxDAT addresses 0x55/0x5D/0x65/0x6D.
- LC write in ch1 restart slot cycle → fetch address is the old lc, pt[1]=old lc+1, lc[1] holds the new value.
